// File: rtl/bp_cce_pkg.sv
// bp_cce_pkg: directory row-reader types, entry layout macros and width helper.
`define DECLARE_BP_CCE_DIR_ENTRY_S(tag_width_mp) \
  typedef struct packed { \
    logic [tag_width_mp-1:0] tag; \
    logic [bp_cce_pkg::bp_coh_bits_gp-1:0] state; \
  } bp_cce_dir_entry_s

`define BP_CCE_DIR_ROW_WIDTH(assoc_mp, tag_width_mp) \
  (2*(assoc_mp)*((tag_width_mp)+bp_cce_pkg::bp_coh_bits_gp))

package bp_cce_pkg;
  localparam int bp_coh_bits_gp = 3;
  typedef enum logic [1:0] {e_IDLE, e_RUN, e_DONE} bp_cce_dir_rd_state_e;
  function automatic int lg(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction
endpackage

// File: rtl/bsg_counter_clear_up.sv
// bsg_counter_clear_up: up counter with synchronous clear taking priority over increment.
module bsg_counter_clear_up #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);
  logic [width_p-1:0] count_q, count_d;
  always_comb count_d = clear_i ? '0 : up_i ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) count_q <= '0;
    else count_q <= count_d;
  assign count_o = count_q;
endmodule

// File: rtl/bp_cce_dir_row_reader.sv
// bp_cce_dir_row_reader: walks every directory row of a set and captures the first LRU hit.
module bp_cce_dir_row_reader
  import bp_cce_pkg::*;
#(
  parameter int num_lce_p          = 4,
  parameter int assoc_p            = 8,
  parameter int sets_p             = 8,
  parameter int tag_width_p        = 8,
  parameter int tag_sets_per_row_p = 2,
  localparam int rows_per_set_lp   = (num_lce_p + 1) / 2,
  localparam int row_width_lp      = `BP_CCE_DIR_ROW_WIDTH(assoc_p, tag_width_p),
  localparam int ram_addr_w_lp     = lg(sets_p * rows_per_set_lp),
  localparam int set_w_lp          = lg(sets_p),
  localparam int lce_w_lp          = lg(num_lce_p),
  localparam int way_w_lp          = lg(assoc_p),
  localparam int row_w_lp          = lg(rows_per_set_lp)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     rd_v_i,
  output logic                     rd_ready_o,
  input  logic [set_w_lp-1:0]      rd_set_i,
  input  logic [lce_w_lp-1:0]      rd_lce_i,
  input  logic [way_w_lp-1:0]      rd_lru_way_i,
  output logic                     ram_v_o,
  output logic [ram_addr_w_lp-1:0] ram_addr_o,
  input  logic [row_width_lp-1:0]  ram_data_i,
  output logic                     row_v_o,
  output logic [row_width_lp-1:0]  row_o,
  output logic [1:0]               row_tag_v_o,
  output logic [row_w_lp-1:0]      row_num_o,
  output logic [lce_w_lp-1:0]      lce_o,
  output logic [way_w_lp-1:0]      lru_way_o,
  input  logic                     lru_v_i,
  input  logic                     lru_cached_excl_i,
  input  logic [tag_width_p-1:0]   lru_tag_i,
  output logic                     done_o,
  output logic                     lru_found_o,
  output logic                     lru_cached_excl_o,
  output logic [tag_width_p-1:0]   lru_tag_o
);
  if (tag_sets_per_row_p != 2) begin : g_bad_tag_sets
    $error("bp_cce_dir_row_reader: tag_sets_per_row_p must be 2");
  end

  bp_cce_dir_rd_state_e state_q, state_d;
  logic [set_w_lp-1:0]    set_q, set_d;
  logic [lce_w_lp-1:0]    lce_q, lce_d;
  logic [way_w_lp-1:0]    way_q, way_d;
  logic                   done_q, done_d;
  logic                   row_v_q, row_v_d;
  logic [row_w_lp-1:0]    row_num_q, row_num_d;
  logic                   found_q, found_d;
  logic                   excl_q, excl_d;
  logic [tag_width_p-1:0] tag_q, tag_d;
  logic [row_w_lp-1:0]    cnt;
  logic                   accept, last, hit;

  bsg_counter_clear_up #(.width_p(row_w_lp)) row_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (accept),
    .up_i     (ram_v_o),
    .count_o  (cnt)
  );

  assign rd_ready_o = state_q == e_IDLE;
  assign ram_v_o    = state_q == e_RUN;
  assign accept     = rd_v_i & rd_ready_o;
  assign last       = cnt == row_w_lp'(rows_per_set_lp - 1);
  assign hit        = row_v_q & lru_v_i & ~found_q;
  assign ram_addr_o = ram_addr_w_lp'(set_q) * ram_addr_w_lp'(rows_per_set_lp) + ram_addr_w_lp'(cnt);

  always_comb begin
    state_d   = accept ? e_RUN : (ram_v_o && last) ? e_DONE : (state_q == e_DONE) ? e_IDLE : state_q;
    done_d    = state_q == e_DONE;
    set_d     = accept ? rd_set_i : set_q;
    lce_d     = accept ? rd_lce_i : lce_q;
    way_d     = accept ? rd_lru_way_i : way_q;
    row_v_d   = ram_v_o;
    row_num_d = cnt;
    found_d   = accept ? 1'b0 : hit ? 1'b1 : found_q;
    excl_d    = accept ? 1'b0 : hit ? lru_cached_excl_i : excl_q;
    tag_d     = accept ? '0 : hit ? lru_tag_i : tag_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q   <= e_IDLE;
      done_q    <= 1'b0;
      set_q     <= '0;
      lce_q     <= '0;
      way_q     <= '0;
      row_v_q   <= 1'b0;
      row_num_q <= '0;
      found_q   <= 1'b0;
      excl_q    <= 1'b0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      set_q     <= set_d;
      lce_q     <= lce_d;
      way_q     <= way_d;
      row_v_q   <= row_v_d;
      row_num_q <= row_num_d;
      found_q   <= found_d;
      excl_q    <= excl_d;
      tag_q     <= tag_d;
    end

  assign row_tag_v_o       = row_v_q ? {(2 * 32'(row_num_q) + 1) < 32'(num_lce_p), 1'b1} : 2'b00;
  assign row_v_o           = row_v_q;
  assign row_num_o         = row_num_q;
  assign row_o             = ram_data_i;
  assign lce_o             = lce_q;
  assign lru_way_o         = way_q;
  assign done_o            = done_q;
  assign lru_found_o       = found_q;
  assign lru_cached_excl_o = excl_q;
  assign lru_tag_o         = tag_q;
endmodule

// File: tb/tb_bp_cce_dir_row_reader.sv
// tb_bp_cce_dir_row_reader: directed checks of the row walk, tag-valid masks and LRU capture on 4- and 3-LCE instances.
module tb_bp_cce_dir_row_reader;
  localparam int RW = 176;
  logic clk = 0, rst_n = 0;
  logic rd_v = 0;
  logic [2:0] rd_set = 0;
  logic [1:0] rd_lce = 0;
  logic [2:0] rd_way = 0;
  logic [RW-1:0] ram_data = '0;
  logic lru_v = 0, lru_excl = 0;
  logic [7:0] lru_tag = 0;
  logic rd_ready, ram_v, row_v, done, found, excl;
  logic [3:0] ram_addr;
  logic [RW-1:0] row;
  logic [1:0] row_tag_v, lce_o;
  logic [0:0] row_num;
  logic [2:0] way_o;
  logic [7:0] tag_o;
  logic rd_ready3, ram_v3, row_v3, done3, found3, excl3;
  logic [3:0] ram_addr3;
  logic [RW-1:0] row3;
  logic [1:0] row_tag_v3, lce_o3;
  logic [0:0] row_num3;
  logic [2:0] way_o3;
  logic [7:0] tag_o3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  bp_cce_dir_row_reader #(.num_lce_p(4), .assoc_p(8), .sets_p(8), .tag_width_p(8)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .rd_v_i(rd_v), .rd_ready_o(rd_ready), .rd_set_i(rd_set),
    .rd_lce_i(rd_lce), .rd_lru_way_i(rd_way), .ram_v_o(ram_v), .ram_addr_o(ram_addr),
    .ram_data_i(ram_data), .row_v_o(row_v), .row_o(row), .row_tag_v_o(row_tag_v),
    .row_num_o(row_num), .lce_o(lce_o), .lru_way_o(way_o), .lru_v_i(lru_v),
    .lru_cached_excl_i(lru_excl), .lru_tag_i(lru_tag), .done_o(done), .lru_found_o(found),
    .lru_cached_excl_o(excl), .lru_tag_o(tag_o));
  bp_cce_dir_row_reader #(.num_lce_p(3), .assoc_p(8), .sets_p(8), .tag_width_p(8)) dut3 (
    .clk_i(clk), .reset_n_i(rst_n), .rd_v_i(rd_v), .rd_ready_o(rd_ready3), .rd_set_i(rd_set),
    .rd_lce_i(rd_lce), .rd_lru_way_i(rd_way), .ram_v_o(ram_v3), .ram_addr_o(ram_addr3),
    .ram_data_i(ram_data), .row_v_o(row_v3), .row_o(row3), .row_tag_v_o(row_tag_v3),
    .row_num_o(row_num3), .lce_o(lce_o3), .lru_way_o(way_o3), .lru_v_i(lru_v),
    .lru_cached_excl_i(lru_excl), .lru_tag_i(lru_tag), .done_o(done3), .lru_found_o(found3),
    .lru_cached_excl_o(excl3), .lru_tag_o(tag_o3));
  task automatic chk(input string t, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_lru(input string t, input logic f, input logic e, input logic [7:0] g);
    chk({t, "_found"}, found, f);
    chk({t, "_excl"}, excl, e);
    chk({t, "_tag"}, tag_o, g);
  endtask
  initial begin
    #12;
    chk("rst_ready", rd_ready, 1'b1);
    chk("rst_ram_v", ram_v, 1'b0);
    chk("rst_row_v", row_v, 1'b0);
    chk("rst_row_tag_v", row_tag_v, 2'b00);
    chk("rst_done", done, 1'b0);
    chk("rst_lce", lce_o, 2'd0);
    check_lru("rst", 1'b0, 1'b0, 8'h00);
    step();
    rst_n = 1;
    step();
    rd_v = 1; rd_set = 3; rd_lce = 2; rd_way = 5;
    step();
    rd_v = 0; rd_set = 7;
    chk("w1_c1_ram_v", ram_v, 1'b1);
    chk("w1_c1_addr", ram_addr, 4'd6);
    chk("w1_c1_ready", rd_ready, 1'b0);
    chk("w1_lce", lce_o, 2'd2);
    chk("w1_way", way_o, 3'd5);
    chk("w1_c1_row_v", row_v, 1'b0);
    step();
    ram_data = {RW{1'b0}} | 176'hA5A5;
    #1;
    chk("w1_c2_addr", ram_addr, 4'd7);
    chk("w1_c2_row_v", row_v, 1'b1);
    chk("w1_c2_row_num", row_num, 1'b0);
    chk("w1_c2_tag_v4", row_tag_v, 2'b11);
    chk("w1_c2_tag_v3", row_tag_v3, 2'b11);
    chk("w1_c2_row", row, 176'hA5A5);
    step();
    lru_v = 1; lru_tag = 8'h2A; lru_excl = 1;
    chk("w1_c3_ram_v", ram_v, 1'b0);
    chk("w1_c3_row_v", row_v, 1'b1);
    chk("w1_c3_row_num", row_num, 1'b1);
    chk("w1_c3_tag_v4", row_tag_v, 2'b11);
    chk("w1_c3_tag_v3", row_tag_v3, 2'b01);
    chk("w1_c3_done", done, 1'b0);
    step();
    lru_v = 0; lru_tag = 0; lru_excl = 0; ram_data = '0;
    chk("w1_c4_done", done, 1'b1);
    chk("w1_c4_done3", done3, 1'b1);
    chk("w1_c4_ready", rd_ready, 1'b1);
    chk("w1_c4_row_v", row_v, 1'b0);
    check_lru("w1_c4", 1'b1, 1'b1, 8'h2A);
    step();
    chk("w1_c5_done", done, 1'b0);
    check_lru("w1_hold", 1'b1, 1'b1, 8'h2A);
    rd_v = 1; rd_set = 0;
    step();
    rd_v = 0;
    check_lru("w2_clear", 1'b0, 1'b0, 8'h00);
    chk("w2_addr0", ram_addr, 4'd0);
    step();
    lru_v = 1; lru_tag = 8'h11; lru_excl = 0;
    step();
    lru_tag = 8'h22; lru_excl = 1;
    step();
    lru_v = 0; lru_tag = 0; lru_excl = 0;
    chk("w2_done", done, 1'b1);
    check_lru("w2", 1'b1, 1'b0, 8'h11);
    rd_v = 1; rd_set = 2;
    step();
    rd_v = 0; lru_v = 1; lru_tag = 8'h77; lru_excl = 1;
    step();
    lru_v = 0; lru_tag = 0; lru_excl = 0;
    step();
    step();
    chk("w3_done", done, 1'b1);
    check_lru("w3_nohit", 1'b0, 1'b0, 8'h00);
    rd_v = 1; rd_set = 1;
    step();
    chk("w4_addr0", ram_addr, 4'd2);
    step();
    chk("w4_addr1", ram_addr, 4'd3);
    lru_v = 1; lru_tag = 8'h33; lru_excl = 1;
    step();
    lru_v = 0; lru_tag = 0; lru_excl = 0;
    chk("w4_c3_ready", rd_ready, 1'b0);
    step();
    rd_set = 5;
    chk("w4_done", done, 1'b1);
    chk("w4_done_ready", rd_ready, 1'b1);
    check_lru("w4_c4", 1'b1, 1'b1, 8'h33);
    step();
    rd_v = 0;
    chk("w4_b2b_ram_v", ram_v, 1'b1);
    chk("w4_b2b_addr", ram_addr, 4'd10);
    chk("w4_b2b_done", done, 1'b0);
    check_lru("w4_b2b_clear", 1'b0, 1'b0, 8'h00);
    step();
    chk("w4_b2b_addr1", ram_addr, 4'd11);
    step();
    step();
    chk("w4_b2b_done2", done, 1'b1);
    step();
    rd_v = 1; rd_set = 4;
    step();
    rd_v = 0;
    chk("w5_running", ram_v, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("w5_rst_ready", rd_ready, 1'b1);
    chk("w5_rst_ram_v", ram_v, 1'b0);
    chk("w5_rst_row_v", row_v, 1'b0);
    step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("w5_no_done", done, 1'b0);
      chk("w5_idle_ram_v", ram_v, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
